// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, output slot indices, op encoding and mstatus layout
package csr_pkg;

    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam int SLOT_MSCRATCH = 0;
    localparam int SLOT_MSTATUS  = 1;
    localparam int SLOT_MCAUSE   = 2;
    localparam int SLOT_MTVEC    = 3;
    localparam int SLOT_MEPC     = 4;
    localparam int SLOT_CYCLE    = 5;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_t;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [63:0] MSTATUS_WMASK = 64'h88;

    // Only these addresses accept writes; cycle, misa, mhartid and anything unknown are rejected.
    function automatic logic csr_writable(input logic [11:0] addr);
        return addr == CSR_MSCRATCH || addr == CSR_MSTATUS || addr == CSR_MCAUSE ||
               addr == CSR_MTVEC || addr == CSR_MEPC;
    endfunction

endpackage

// File: rtl/csr_regfile_alu.sv
// csr_alu: computes the CSRRW/CSRRS/CSRRC result from the old value and the operand
module csr_alu
    import csr_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] old,
    input  logic [N-1:0] wdata,
    input  csr_op_t      op,
    output logic [N-1:0] result
);

    // Write replaces, set ORs in, clear masks out; no-op passes the old value through.
    always_comb
        result = op == OP_WRITE ? wdata :
                 op == OP_SET   ? (old | wdata) :
                 op == OP_CLEAR ? (old & ~wdata) : old;

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage, cycle counter and trap/MRET side effects
module csr_regfile
    import csr_pkg::*;
#(
    parameter int N     = 64,
    parameter int W_CSR = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         csr_we,
    input  logic [1:0]   csr_op,
    input  logic [11:0]  csr_addr,
    input  logic [N-1:0] csr_wdata,
    input  logic         trap,
    input  logic [N-1:0] trap_pc,
    input  logic [N-1:0] trap_cause,
    input  logic         mret,
    output logic [N-1:0] csr_out [W_CSR],
    output logic [N-1:0] trap_vector,
    output logic [N-1:0] epc,
    output logic         csr_illegal
);

    logic [N-1:0] mscratch_q, mcause_q, mtvec_q, mepc_q, cycle_q;
    logic         mie_q, mpie_q;
    logic [N-1:0] mstatus, old, alu_res;
    logic         wr;
    csr_op_t      op;

    assign op          = csr_op_t'(csr_op);
    assign csr_illegal = csr_we && op != OP_NONE && !csr_writable(csr_addr);
    assign wr          = csr_we && op != OP_NONE && !csr_illegal && !trap && !mret;
    assign trap_vector = mtvec_q;
    assign epc         = mepc_q;

    // mstatus view: MPP hardwired to machine mode, only MIE/MPIE are stored.
    always_comb begin
        mstatus = '0;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus[MSTATUS_MIE]  = mie_q;
        mstatus[MSTATUS_MPIE] = mpie_q;
    end

    // Current value of the addressed register feeds the read-modify-write.
    always_comb
        old = csr_addr == CSR_MSCRATCH ? mscratch_q :
              csr_addr == CSR_MSTATUS  ? mstatus :
              csr_addr == CSR_MCAUSE   ? mcause_q :
              csr_addr == CSR_MTVEC    ? mtvec_q :
              csr_addr == CSR_MEPC     ? mepc_q : '0;

    csr_alu #(.N(N)) u_alu (
        .old    (old),
        .wdata  (csr_wdata),
        .op     (op),
        .result (alu_res)
    );

    // State update: counter always runs; trap beats mret beats a CSR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mscratch_q <= '0;
            mcause_q   <= '0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            cycle_q    <= '0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
        end else begin
            cycle_q <= cycle_q + N'(1);
            if (trap) begin
                mepc_q   <= trap_pc & ~N'(3);
                mcause_q <= trap_cause;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (wr) begin
                if (csr_addr == CSR_MSCRATCH) mscratch_q <= alu_res;
                if (csr_addr == CSR_MCAUSE)   mcause_q   <= alu_res;
                if (csr_addr == CSR_MTVEC)    mtvec_q    <= alu_res & ~N'(3);
                if (csr_addr == CSR_MEPC)     mepc_q     <= alu_res & ~N'(3);
                if (csr_addr == CSR_MSTATUS) begin
                    mie_q  <= alu_res[MSTATUS_MIE];
                    mpie_q <= alu_res[MSTATUS_MPIE];
                end
            end
        end
    end

    // Present registers in the decoder's slot order; unused slots read zero.
    always_comb begin
        for (int i = 0; i < W_CSR; i++) csr_out[i] = '0;
        csr_out[SLOT_MSCRATCH] = mscratch_q;
        csr_out[SLOT_MSTATUS]  = mstatus;
        csr_out[SLOT_MCAUSE]   = mcause_q;
        csr_out[SLOT_MTVEC]    = mtvec_q;
        csr_out[SLOT_MEPC]     = mepc_q;
        csr_out[SLOT_CYCLE]    = cycle_q;
    end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine-mode CSR storage for the RV64 core; the stage directly upstream of the CSR read decoder.
- Holds the writable CSRs and the free-running cycle counter, and presents them as the csr_out array in the decoder's fixed slot order.
- Applies CSRRW/CSRRS/CSRRC updates from the execute stage, and trap-entry/MRET side effects from the trap controller.
- Supplies the trap vector and return PC to the fetch stage.

Parameters:
- N, 64, register width.
- W_CSR, 256, csr_out array depth; slots 0-5 are used, the rest read 0.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- csr_we  in  1  CSR instruction commits this cycle.
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear.
- csr_addr  in  12  target CSR address.
- csr_wdata  in  N  rs1 value or zero-extended uimm.
- trap  in  1  take trap this cycle.
- trap_pc  in  N  PC of the faulting instruction.
- trap_cause  in  N  mcause value for this trap.
- mret  in  1  MRET commits this cycle.
- csr_out  out  N x W_CSR  slots: [0] mscratch 0x340, [1] mstatus 0x300, [2] mcause 0x342, [3] mtvec 0x305, [4] mepc 0x341, [5] cycle 0xC00; others 0.
- trap_vector  out  N  {mtvec[N-1:2], 2'b00}.
- epc  out  N  current mepc.
- csr_illegal  out  1  combinational; asserts for a write attempt to a read-only or unimplemented address.

Behaviour:
- Reset (rst_n low, async):
  - mscratch, mcause, mepc, mtvec, cycle = 0.
  - mstatus = 0 except MPP[12:11] = 2'b11.
  - All outputs therefore reset to 0, except csr_out[1] = 0x1800.
- Cycle counter:
  - Increments by 1 every clock, unconditionally. This includes cycles carrying a trap, MRET or stall.
  - Wraps from 2^N-1 to 0.
  - Never writable.
- CSR write:
  - Occurs when csr_we=1, csr_op != 00, and the address is writable.
  - new = csr_wdata (01); old | csr_wdata (10); old & ~csr_wdata (11). Here old is the current register value.
  - Written at the next rising edge, so a back-to-back read sees the new value one cycle later. No bypass.
  - Set/clear with csr_wdata = 0 leaves the register unchanged. It is still a legal access.
- Write masks:
  - mstatus: only MIE[3] and MPIE[7] are writable. MPP is hardwired 11. All other bits read 0.
  - mepc: bits [1:0] forced 0.
  - mtvec: bits [1:0] forced 0 (direct mode only).
  - mscratch and mcause: full width.
- csr_illegal:
  - Asserts when csr_we=1 and csr_op != 00 and the address is one of 0xC00, 0x301, 0xF11-0xF14, or outside the implemented set.
  - No register changes in that case.
  - Reads (csr_op = 00) never assert it.
- Trap entry (trap=1):
  - mepc <= trap_pc with bits [1:0] cleared.
  - mcause <= trap_cause.
  - mstatus.MPIE <= MIE; mstatus.MIE <= 0.
- MRET (mret=1, trap=0):
  - mstatus.MIE <= MPIE; mstatus.MPIE <= 1.
- Priority when events coincide in the same cycle:
  - trap > mret > CSR write. The lower-priority events are discarded entirely; the pipeline flushes them.
  - csr_illegal is still evaluated combinationally.
- Reset asserted mid-operation: all state returns to reset values immediately; any pending write is lost.
- No handshake: every input is a single-cycle qualified strobe.

Decomposition:
- Package csr_pkg:
  - Address localparams: CSR_MSCRATCH, CSR_MSTATUS, CSR_MCAUSE, CSR_MTVEC, CSR_MEPC, CSR_CYCLE, CSR_MISA, CSR_MHARTID.
  - Slot index constants 0-5.
  - csr_op_t enum.
  - mstatus bit positions MIE, MPIE, MPP.
  - MSTATUS_WMASK.
- Sub-module csr_alu: combinational old/wdata/op -> new value. Instantiated once; its output is masked per target register.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, release -> csr_out[1]=0x1800, all other slots 0, trap_vector=0, csr_illegal=0; cycle counter reads 1 after the first edge.
2. Write/set/clear mscratch:
   - csrrw 0x340 wdata=0xF0 -> csr_out[0]=0xF0 next cycle.
   - set 0x0F -> 0xFF.
   - clear 0xF0 -> 0x0F.
3. mstatus mask and vectors:
   - Write 0x340 to mtvec -> trap_vector=0x340.
   - Write 0xFFFF...FFFF to 0x300 -> csr_out[1]=0x1888.
4. Trap then MRET:
   - With MIE=1, pulse trap with trap_pc=0x8000_0006, cause=2 -> mepc=0x8000_0004, mcause=2, MIE=0, MPIE=1.
   - Then pulse mret -> MIE=1, MPIE=1.
5. Illegal and priority:
   - Write to 0xC00 -> csr_illegal=1, cycle keeps incrementing.
   - Write to 0xF14 -> csr_illegal=1, no state change.
   - trap and csr_we to 0x341 in the same cycle -> mepc = trap_pc; the CSR write is dropped.
6. Wrap: force cycle=0xFFFF_FFFF_FFFF_FFFF via a backdoor deposit -> reads 0 on the next cycle.
